deco_reg_ctrl: RTL and testbench

//  Capture sequencer for the three-digit register bank (decoder + 3x4-bit registers).
//  - Accepts digits from the keypad front-end over a valid/ready handshake.
//  - Drives the 2-bit slot select and the 4-bit digit bus so each digit lands in slot 1, 2, 3 in order.
//  - Signals completion to the accumulator datapath.
//  - Slot select 2'b00 means "no write"; the bank holds its contents.

---
 rtl/deco_reg_pkg.sv | 34 +++
 rtl/deco_idle_timer.sv | 43 ++++
 rtl/deco_reg_ctrl.sv | 175 +++++++++++++++++
 tb/tb_deco_reg_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/deco_reg_pkg.sv
// ---------------------------------------------------------------------------
// deco_reg_pkg
// Shared types and constants for the three-digit capture sequencer.
//   state_t   : capture FSM states
//   SEL_*     : slot-select encodings driven to the register bank
//   DIGIT_W   : width of one key code / register slot
//   next_slot : slot advance helper (1 -> 2 -> 3; anything else restarts at 1)
// ---------------------------------------------------------------------------
package deco_reg_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_K = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_S1   = 2'b01;
  localparam logic [1:0] SEL_S2   = 2'b10;
  localparam logic [1:0] SEL_S3   = 2'b11;

  // Slot 3 is the last one; no wrap is ever requested from there by the FSM.
  function automatic logic [1:0] next_slot(input logic [1:0] slot);
    case (slot)
      SEL_S1:  next_slot = SEL_S2;
      SEL_S2:  next_slot = SEL_S3;
      default: next_slot = SEL_S1;
    endcase
  endfunction

endpackage

// File: rtl/deco_idle_timer.sv
// ---------------------------------------------------------------------------
// deco_idle_timer
// 16-bit inactivity counter for the capture sequencer (used only when the
// design is built with DECO_TIMEOUT_EN).
// Ports:
//   i_clk     in  1  clock, rising edge
//   i_reset   in  1  asynchronous active-high reset
//   i_load    in  1  restart count from zero (entering the wait state)
//   i_clear   in  1  restart count from zero (keypad activity)
//   i_enable  in  1  count this cycle
//   o_expire  out 1  count has reached LIMIT-1 while enabled
// ---------------------------------------------------------------------------
module deco_idle_timer #(
  parameter logic [15:0] LIMIT = 16'd1000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  logic [15:0] r_cnt;

  // Inactivity counter: zeroed by load/clear, advanced while enabled.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= 16'd0;
    end else if (i_load || i_clear) begin
      r_cnt <= 16'd0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 16'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Depends only on the count and the enable, so the FSM can use it without
  // forming a loop through i_load.
  assign o_expire = i_enable && (r_cnt == (LIMIT - 16'd1));

endmodule

// File: rtl/deco_reg_ctrl.sv
// ---------------------------------------------------------------------------
// deco_reg_ctrl
// Capture sequencer for the three-digit register bank. Takes digits from the
// keypad over valid/ready, writes them into slots 1, 2, 3 in order through
// the slot-select / digit bus, then pulses done.
// Optional feature macro: DECO_TIMEOUT_EN (idle timeout while waiting for a
// key; without it the controller waits indefinitely and o_timeout is 0).
// Ports:
//   i_clk        in  1  clock, rising edge
//   i_reset      in  1  asynchronous active-high reset
//   i_start      in  1  begin a capture (IDLE only)
//   i_abort      in  1  cancel capture from any state
//   i_key_valid  in  1  keypad offers a digit
//   i_key_data   in  4  offered digit code
//   o_key_ready  out 1  digit accepted this cycle when valid
//   o_sel        out 2  slot select (00 none, 01/10/11 slot 1/2/3)
//   o_digit      out 4  digit bus, meaningful while o_sel != 00
//   o_busy       out 1  capture in progress
//   o_done       out 1  one-cycle pulse after slot 3 is written
//   o_key_err    out 1  one-cycle pulse: offered code above MAX_DIGIT
//   o_timeout    out 1  one-cycle pulse: capture abandoned for inactivity
// ---------------------------------------------------------------------------
module deco_reg_ctrl
  import deco_reg_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX_DIGIT      = 4'd9,
  parameter logic [15:0]        TIMEOUT_CYCLES = 16'd1000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_key_valid,
  input  logic [DIGIT_W-1:0] i_key_data,
  output logic               o_key_ready,
  output logic [1:0]         o_sel,
  output logic [DIGIT_W-1:0] o_digit,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_key_err,
  output logic               o_timeout
);

  state_t               r_state;
  logic [1:0]           r_slot;
  logic [DIGIT_W-1:0]   r_digit;
  logic [1:0]           r_sel;
  logic                 r_key_ready;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_key_err;
  logic                 r_timeout;

  state_t               w_state_nxt;
  logic [1:0]           w_slot_nxt;
  logic [DIGIT_W-1:0]   w_digit_nxt;
  logic                 w_key_err_nxt;
  logic                 w_timeout_nxt;
  logic                 w_tmr_expire;

`ifdef DECO_TIMEOUT_EN
  logic w_tmr_load;
  logic w_tmr_enable;

  assign w_tmr_load   = (w_state_nxt == WAIT_K) && (r_state != WAIT_K);
  assign w_tmr_enable = (r_state == WAIT_K);

  deco_idle_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_tmr_load),
    .i_clear  (i_key_valid),
    .i_enable (w_tmr_enable),
    .o_expire (w_tmr_expire)
  );
`else
  // No timer: expiry never fires; the parameter stays referenced so both
  // builds share one parameter list.
  assign w_tmr_expire = 1'b0 & (TIMEOUT_CYCLES != 16'd0);
`endif

  // Next-state, slot and digit-latch decisions; abort outranks everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_slot_nxt    = r_slot;
    w_digit_nxt   = r_digit;
    w_key_err_nxt = 1'b0;
    w_timeout_nxt = 1'b0;
    if (i_abort) begin
      // Key offered in the same cycle is deliberately not latched.
      w_state_nxt = IDLE;
      w_slot_nxt  = SEL_S1;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            w_state_nxt = WAIT_K;
            w_slot_nxt  = SEL_S1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        WAIT_K: begin
          if (i_key_valid) begin
            if (i_key_data <= MAX_DIGIT) begin
              w_state_nxt = WRITE;
              w_digit_nxt = i_key_data;
            end else begin
              w_key_err_nxt = 1'b1;
            end
          end else if (w_tmr_expire) begin
            w_state_nxt   = IDLE;
            w_slot_nxt    = SEL_S1;
            w_timeout_nxt = 1'b1;
          end else begin
            w_state_nxt = WAIT_K;
          end
        end
        WRITE: begin
          if (r_slot == SEL_S3) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = WAIT_K;
            w_slot_nxt  = next_slot(r_slot);
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
          w_slot_nxt  = SEL_S1;
        end
        default: begin
          w_state_nxt = IDLE;
          w_slot_nxt  = SEL_S1;
        end
      endcase
    end
  end

  // State and registered outputs; outputs are computed from the next state so
  // they line up with the state they describe.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_slot      <= SEL_S1;
      r_digit     <= {DIGIT_W{1'b0}};
      r_sel       <= SEL_NONE;
      r_key_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_key_err   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_slot      <= w_slot_nxt;
      r_digit     <= w_digit_nxt;
      r_sel       <= (w_state_nxt == WRITE) ? w_slot_nxt : SEL_NONE;
      r_key_ready <= (w_state_nxt == WAIT_K);
      r_busy      <= (w_state_nxt != IDLE);
      r_done      <= (w_state_nxt == DONE);
      r_key_err   <= w_key_err_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign o_key_ready = r_key_ready;
  assign o_sel       = r_sel;
  assign o_digit     = r_digit;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_key_err   = r_key_err;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_deco_reg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_deco_reg_ctrl
// Directed bench for deco_reg_ctrl: normal capture, illegal keys, abort,
// reset mid-capture, idle timeout (with or without DECO_TIMEOUT_EN) and
// ignored inputs. Inputs change 1 ns after a rising edge; outputs are
// checked at that same point.
// ---------------------------------------------------------------------------
module tb_deco_reg_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic       key_valid;
  logic [3:0] key_data;
  logic       key_ready;
  logic [1:0] sel;
  logic [3:0] digit;
  logic       busy;
  logic       done;
  logic       key_err;
  logic       timeout;

  int n_assert = 0;
  int n_fail   = 0;

  deco_reg_ctrl #(
    .MAX_DIGIT      (4'd9),
    .TIMEOUT_CYCLES (16'd8)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_abort     (abort),
    .i_key_valid (key_valid),
    .i_key_data  (key_data),
    .o_key_ready (key_ready),
    .o_sel       (sel),
    .o_digit     (digit),
    .o_busy      (busy),
    .o_done      (done),
    .o_key_err   (key_err),
    .o_timeout   (timeout)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Digit is only compared when a slot write is expected.
  task automatic chk_out(input string tag, input logic [1:0] e_sel, input logic [3:0] e_dig,
                         input logic e_kr, input logic e_busy, input logic e_done,
                         input logic e_err, input logic e_tmo);
    logic [15:0] obs;
    logic [15:0] exp;
    obs = {3'b000, sel, (e_sel == 2'b00) ? 4'd0 : digit, key_ready, busy, done, key_err, timeout};
    exp = {3'b000, e_sel, (e_sel == 2'b00) ? 4'd0 : e_dig, e_kr, e_busy, e_done, e_err, e_tmo};
    chk(tag, obs, exp);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    key_valid = 1'b0;
    key_data  = 4'd0;
    tick();
    tick();
    chk_out("reset_outputs", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_digit", {12'd0, digit}, 16'd0);
    reset = 1'b0;
    tick();

    // T1 normal capture 1,2,3
    start = 1'b1; tick(); start = 1'b0;
    chk_out("t1_wait1", 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    key_valid = 1'b1; key_data = 4'd1; tick(); key_valid = 1'b0;
    chk_out("t1_write1", 2'b01, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("t1_wait2", 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    key_valid = 1'b1; key_data = 4'd2; tick(); key_valid = 1'b0;
    chk_out("t1_write2", 2'b10, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    key_valid = 1'b1; key_data = 4'd3; tick(); key_valid = 1'b0;
    chk_out("t1_write3", 2'b11, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("t1_done", 2'b00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("t1_idle", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // T6 key_valid in IDLE ignored, start in WAIT_K ignored
    key_valid = 1'b1; key_data = 4'd4; tick(); key_valid = 1'b0;
    chk_out("t6_key_in_idle", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; tick();
    chk_out("t6_start", 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); start = 1'b0;
    chk_out("t6_start_in_wait", 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // T2 illegal keys, boundary 9 accepted / A rejected
    key_valid = 1'b1; key_data = 4'hC; tick(); key_valid = 1'b0;
    chk_out("t2_err_c", 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("t2_err_clear", 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    key_valid = 1'b1; key_data = 4'd5; tick(); key_valid = 1'b0;
    chk_out("t2_slot1_5", 2'b01, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    key_valid = 1'b1; key_data = 4'hA; tick();
    chk_out("t2_err_a", 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    key_data = 4'd9; tick(); key_valid = 1'b0;
    chk_out("t2_slot2_9", 2'b10, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // T3 abort with a key transfer (slot 3 pending)
    key_valid = 1'b1; key_data = 4'd7; abort = 1'b1; tick();
    key_valid = 1'b0; abort = 1'b0;
    chk_out("t3_abort_idle", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("t3_no_done", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    key_valid = 1'b1; key_data = 4'd4; tick(); key_valid = 1'b0;
    chk_out("t3_restart_slot1", 2'b01, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    key_valid = 1'b1; key_data = 4'd6; tick(); key_valid = 1'b0;
    chk_out("t4_in_write2", 2'b10, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // T4 asynchronous reset in WRITE
    reset = 1'b1; #1;
    chk_out("t4_async_reset", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    key_valid = 1'b1; key_data = 4'd8; tick(); key_valid = 1'b0;
    chk_out("t4_restart_slot1", 2'b01, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // abort in WRITE: pulse already out, then IDLE
    key_valid = 1'b1; key_data = 4'd2; tick(); key_valid = 1'b0;
    chk_out("abort_write_pulse", 2'b10, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk_out("abort_write_idle", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // T5 idle timeout, limit 8, counted from WAIT_K re-entry
    start = 1'b1; tick(); start = 1'b0;
    key_valid = 1'b1; key_data = 4'd1; tick(); key_valid = 1'b0;
    chk_out("t5_write1", 2'b01, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk_out($sformatf("t5_wait_%0d", i), 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    tick();
`ifdef DECO_TIMEOUT_EN
    chk_out("t5_timeout_pulse", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("t5_timeout_clear", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    chk_out("t5_no_timeout", 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk_out("t5_still_busy", 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk_out("t5_abort_idle", 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
